// File: rtl/imm_ext_pipe.sv
// Moded immediate / load-data extender with a valid/ready handshake and a
// two-entry skid buffer (output register plus one skid slot).
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OFF_W = $clog2(OUT_W/8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_data,
  input  logic [2:0]       in_mode,
  input  logic [OFF_W-1:0] in_off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [15:0]      err_count
);

  localparam logic [2:0] M_SEXT = 3'd0;
  localparam logic [2:0] M_ZEXT = 3'd1;
  localparam logic [2:0] M_LUI  = 3'd2;
  localparam logic [2:0] M_LB   = 3'd3;
  localparam logic [2:0] M_LBU  = 3'd4;
  localparam logic [2:0] M_LH   = 3'd5;
  localparam logic [2:0] M_LHU  = 3'd6;

  logic [OUT_W-1:0] res_data;
  logic             res_err;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;
  logic             in_ready_q,   in_ready_d;
  logic [15:0]      err_cnt_q,    err_cnt_d;

  logic in_fire, out_fire;

  // Byte/halfword extraction: shift the addressed lane down to bit 0.
  always_comb begin
    byte_v   = 8'(in_data >> {in_off, 3'b000});
    half_v   = 16'(in_data >> {in_off, 3'b000});
    res_data = '0;
    res_err  = 1'b0;
    case (in_mode)
      M_SEXT: res_data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data[IN_W-1:0]};
      M_ZEXT: res_data = {{(OUT_W-IN_W){1'b0}}, in_data[IN_W-1:0]};
      M_LUI:  res_data = {in_data[IN_W-1:0], {(OUT_W-IN_W){1'b0}}};
      M_LB:   res_data = {{(OUT_W-8){byte_v[7]}}, byte_v};
      M_LBU:  res_data = {{(OUT_W-8){1'b0}}, byte_v};
      M_LH, M_LHU: begin
        if (in_off[0]) begin
          res_err = 1'b1;
        end else if (in_mode == M_LH) begin
          res_data = {{(OUT_W-16){half_v[15]}}, half_v};
        end else begin
          res_data = {{(OUT_W-16){1'b0}}, half_v};
        end
      end
      default: res_err = 1'b1;
    endcase
  end

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    err_cnt_d    = err_cnt_q;

    if (out_fire) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_data_d = res_data;
        out_err_d  = res_err;
      end else begin
        out_valid_d = 1'b0;
      end
      if (out_err_q && err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end else if (in_fire) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_err_d   = res_err;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = res_data;
        skid_err_d   = res_err;
      end
    end

    // Registered ready: it reflects the skid state after this edge.
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed, table-driven bench for imm_ext_pipe (32-bit and 64-bit builds).
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_mode;
  logic [1:0]  in_off;
  logic [15:0] err_count;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_err;
  logic [63:0] w_in_data, w_out_data;
  logic [2:0]  w_in_mode, w_in_off;
  logic [15:0] w_err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) d32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_off(in_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_count(err_count));

  imm_ext_pipe #(.IN_W(16), .OUT_W(64)) d64 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .in_mode(w_in_mode), .in_off(w_in_off),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .out_err(w_out_err), .err_count(w_err_count));

  always @(posedge clk)
    if (!reset && out_valid && out_ready) got.push_back(out_data);

  typedef struct {
    logic [2:0]  mode;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] m, input logic [31:0] d, output int cyc);
    logic acc;
    cyc = 0;
    in_mode = m; in_data = d; in_off = 2'd0; in_valid = 1'b1;
    do begin
      acc = in_ready;
      step();
      cyc++;
    end while (!acc && cyc < 20);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  initial begin
    int exp_cnt;
    int cyc;
    int total;
    int n;

    vecs[0]  = '{3'd0, 2'd0, 32'h0000_8001, 32'hFFFF_8001, 1'b0};
    vecs[1]  = '{3'd1, 2'd0, 32'h0000_8001, 32'h0000_8001, 1'b0};
    vecs[2]  = '{3'd2, 2'd0, 32'h0000_8001, 32'h8001_0000, 1'b0};
    vecs[3]  = '{3'd3, 2'd0, 32'h80F0_7F81, 32'hFFFF_FF81, 1'b0};
    vecs[4]  = '{3'd4, 2'd3, 32'h80F0_7F81, 32'h0000_0080, 1'b0};
    vecs[5]  = '{3'd5, 2'd2, 32'h80F0_7F81, 32'hFFFF_80F0, 1'b0};
    vecs[6]  = '{3'd6, 2'd0, 32'h80F0_7F81, 32'h0000_7F81, 1'b0};
    vecs[7]  = '{3'd5, 2'd1, 32'h80F0_7F81, 32'h0000_0000, 1'b1};
    vecs[8]  = '{3'd7, 2'd0, 32'h80F0_7F81, 32'h0000_0000, 1'b1};
    vecs[9]  = '{3'd3, 2'd1, 32'h80F0_7F81, 32'h0000_007F, 1'b0};
    vecs[10] = '{3'd4, 2'd2, 32'h80F0_7F81, 32'h0000_00F0, 1'b0};
    vecs[11] = '{3'd5, 2'd0, 32'h80F0_7F81, 32'h0000_7F81, 1'b0};
    vecs[12] = '{3'd6, 2'd2, 32'h80F0_7F81, 32'h0000_80F0, 1'b0};
    vecs[13] = '{3'd6, 2'd3, 32'h80F0_7F81, 32'h0000_0000, 1'b1};
    vecs[14] = '{3'd0, 2'd0, 32'hFFFF_1234, 32'h0000_1234, 1'b0};
    vecs[15] = '{3'd1, 2'd0, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0};
    vecs[16] = '{3'd3, 2'd2, 32'h80F0_7F81, 32'hFFFF_FFF0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_off = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = '0; w_in_off = '0;
    step(); step();
    reset = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", in_ready, 1);

    // Each vector: accept, check result one cycle later, then drain it.
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      in_mode = vecs[i].mode; in_off = vecs[i].off; in_data = vecs[i].data;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), out_err, vecs[i].exp_err);
      step();
      if (vecs[i].exp_err) exp_cnt++;
      chk($sformatf("v%0d_err_count", i), err_count, exp_cnt);
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Backpressure: two entries fill, third request waits.
    got.delete();
    expq = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0011, cyc);
    chk("bp_ready_after_1st", in_ready, 1);
    send(3'd1, 32'h0000_0022, cyc);
    chk("bp_ready_after_2nd", in_ready, 0);
    step(); step();
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 32'h0000_0011);
    out_ready = 1'b1;
    send(3'd1, 32'h0000_0033, cyc);
    chk("bp_3rd_wait", cyc, 2);
    send(3'd1, 32'h0000_0044, cyc);
    step(); step();
    chk("bp_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp_order%0d", i), got[i], expq[i]);

    // Full-rate streaming: one acceptance per cycle.
    got.delete();
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send(3'd1, 32'h100 + i, cyc);
      total += cyc;
    end
    step();
    chk("tput_cycles", total, 8);
    chk("tput_results", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("tput_data%0d", i), got[i], 32'h100 + i);

    // Drive err_count up to 16'hFFFE with back-to-back reserved-mode requests.
    n = 16'hFFFE - exp_cnt;
    in_mode = 3'd7; in_off = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < n; i++) step();
    in_valid = 1'b0;
    step();
    chk("sat_preload", err_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) send(3'd7, 32'h0, cyc);
    step();
    chk("sat_hold", err_count, 16'hFFFF);

    // Reset with both entries occupied discards them.
    got.delete();
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0AAA, cyc);
    send(3'd7, 32'h0000_0BBB, cyc);
    chk("rst_mid_full", in_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_err_count", err_count, 0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("rst_mid_no_ghost", got.size(), 0);

    // 64-bit build.
    w_in_mode = 3'd0; w_in_off = 3'd0; w_in_data = 64'h0000_0000_0000_8000;
    w_in_valid = 1'b1;
    step();
    chk("w64_sext", w_out_data, 64'hFFFF_FFFF_FFFF_8000);
    w_in_mode = 3'd4; w_in_off = 3'd7; w_in_data = 64'hAB00_0000_0000_0000;
    step();
    w_in_valid = 1'b0;
    chk("w64_lbu7", w_out_data, 64'h0000_0000_0000_00AB);
    chk("w64_err", w_out_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
